prbs_checker: RTL and testbench

- Receive-side counterpart of the team's 8-bit Fibonacci LFSR pattern generator.
- Consumes the serial bit stream the generator emits and self-synchronises to it.
- Once locked, flags and counts every bit that deviates from the predicted sequence, giving link/BER checking for the serial path.
- Bit-level only; any framing or word alignment belongs upstream.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_history.sv | 32 +++
 rtl/prbs_checker.sv | 168 ++++++++++++++++
 tb/tb_prbs_checker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR pattern generator and its checker.
package lfsr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Feedback taps, expressed as offsets below the register size (bit n-k of the history).
    localparam int unsigned TAP_A = 1;
    localparam int unsigned TAP_B = 3;
    localparam int unsigned TAP_C = 5;

    localparam int unsigned DEF_N        = 8;
    localparam int unsigned DEF_LOCK_CNT = 16;
    localparam int unsigned DEF_LOSS_CNT = 4;
    localparam int unsigned DEF_WINDOW   = 64;
    localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/lfsr_history.sv
// Shift register of the most recent n received bits with next-bit prediction.
module lfsr_history
    import lfsr_pkg::*;
#(
    parameter int unsigned n = DEF_N
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic pred_c,
    output logic zero_c
);

    logic [n-1:0] h;

    // h[0] holds the newest bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
        end else if (clr) begin
            h <= '0;
        end else if (en) begin
            h <= {h[n-2:0], din};
        end
    end

    assign pred_c = h[n-TAP_A] ^ h[n-TAP_B] ^ h[n-TAP_C];
    assign zero_c = (h == '0);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit LFSR serial stream: lock detection,
// loss-of-lock windowing and saturating error/bit counters.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned n        = DEF_N,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
    parameter int unsigned WINDOW   = DEF_WINDOW,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned FILL_W  = $clog2(n + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW + 1);

    state_t             state, state_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [MATCH_W-1:0] match_cnt, match_cnt_nxt;
    logic [MISS_W-1:0]  miss_cnt, miss_cnt_nxt;
    logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
    logic               locked_nxt;
    logic               error_nxt;
    logic [CNT_W-1:0]   err_count_nxt;
    logic [CNT_W-1:0]   bit_count_nxt;

    logic               hist_en_c;
    logic               hist_clr_c;
    logic               hist_din_c;
    logic               pred_c;
    logic               zero_c;
    logic               mismatch_c;
    logic               err_inc_c;
    logic               bit_inc_c;
    logic [MISS_W-1:0]  miss_sum_c;

    lfsr_history #(
        .n (n)
    ) u_history (
        .clk    (clk),
        .reset  (reset),
        .en     (hist_en_c),
        .clr    (hist_clr_c),
        .din    (hist_din_c),
        .pred_c (pred_c),
        .zero_c (zero_c)
    );

    assign mismatch_c = bit_in ^ pred_c;
    assign miss_sum_c = miss_cnt + MISS_W'(mismatch_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            win_cnt   <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            match_cnt <= match_cnt_nxt;
            miss_cnt  <= miss_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            locked    <= locked_nxt;
            error     <= error_nxt;
            err_count <= err_count_nxt;
            bit_count <= bit_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_nxt      = fill;
        match_cnt_nxt = match_cnt;
        miss_cnt_nxt  = miss_cnt;
        win_cnt_nxt   = win_cnt;
        locked_nxt    = locked;
        error_nxt     = 1'b0;
        hist_en_c     = 1'b0;
        hist_clr_c    = 1'b0;
        hist_din_c    = bit_in;
        err_inc_c     = 1'b0;
        bit_inc_c     = 1'b0;

        if (bit_valid) begin
            case (state)
                SEARCH: begin
                    hist_en_c  = 1'b1;
                    hist_din_c = bit_in;
                    if (fill != FILL_W'(n)) begin
                        fill_nxt = fill + FILL_W'(1);
                    end else if (!mismatch_c && !zero_c) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_nxt     = LOCKED;
                            locked_nxt    = 1'b1;
                            match_cnt_nxt = '0;
                            miss_cnt_nxt  = '0;
                            win_cnt_nxt   = '0;
                        end else begin
                            match_cnt_nxt = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        // An all-zero history trivially predicts zeros; never trust it.
                        match_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Shift in the prediction so one corrupt bit produces exactly one error.
                    hist_en_c  = 1'b1;
                    hist_din_c = pred_c;
                    bit_inc_c  = 1'b1;
                    err_inc_c  = mismatch_c;
                    error_nxt  = mismatch_c;
                    if (miss_sum_c == MISS_W'(LOSS_CNT)) begin
                        state_nxt     = SEARCH;
                        locked_nxt    = 1'b0;
                        fill_nxt      = '0;
                        match_cnt_nxt = '0;
                        miss_cnt_nxt  = '0;
                        win_cnt_nxt   = '0;
                        hist_clr_c    = 1'b1;
                    end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        win_cnt_nxt  = '0;
                        miss_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt  = win_cnt + WIN_W'(1);
                        miss_cnt_nxt = miss_sum_c;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                end
            endcase
        end

        // Saturating counters; a clear coinciding with an increment leaves the new event counted.
        err_count_nxt = err_count;
        if (clear_counts) begin
            err_count_nxt = CNT_W'(err_inc_c);
        end else if (err_inc_c && (err_count != '1)) begin
            err_count_nxt = err_count + CNT_W'(1);
        end

        bit_count_nxt = bit_count;
        if (clear_counts) begin
            bit_count_nxt = CNT_W'(bit_inc_c);
        end else if (bit_inc_c && (bit_count != '1)) begin
            bit_count_nxt = bit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker driven by a behavioural copy of the 8-bit pattern generator.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_counts;
    logic        locked;
    logic        error;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  g;

    prbs_checker dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .clear_counts (clear_counts),
        .locked       (locked),
        .error        (error),
        .err_count    (err_count),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic b, input logic v, input logic clr);
        bit_in       = b;
        bit_valid    = v;
        clear_counts = clr;
        @(posedge clk);
        #1;
        bit_valid    = 1'b0;
        clear_counts = 1'b0;
        bit_in       = 1'b0;
    endtask

    // Generator: next bit = x[t-8] ^ x[t-6] ^ x[t-4], g[0] newest.
    task automatic gen(output logic b);
        b = g[7] ^ g[5] ^ g[3];
        g = {g[6:0], b};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        g     = 8'h01;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        clear_counts = 1'b0;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else n_pass++;
        n_checks++;
        if (error !== 1'b0) $display("FAIL reset_error got=%b exp=0", error); else n_pass++;
        n_checks++;
        if (err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd0) $display("FAIL reset_bit_count got=%0d exp=0", bit_count); else n_pass++;
    endtask

    task automatic test_clean_stream();
        logic b;
        int   lock_bit = -1;
        int   err_seen = 0;
        g = 8'h01;
        reset = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (locked && lock_bit < 0) lock_bit = i;
            if (error) err_seen++;
        end
        n_checks++;
        if (lock_bit !== 24) $display("FAIL clean_lock_bit got=%0d exp=24", lock_bit); else n_pass++;
        n_checks++;
        if (err_count !== 16'd0) $display("FAIL clean_err_count got=%0d exp=0", err_count); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd976) $display("FAIL clean_bit_count got=%0d exp=976", bit_count); else n_pass++;
        n_checks++;
        if (err_seen !== 0) $display("FAIL clean_error_pulses got=%0d exp=0", err_seen); else n_pass++;
    endtask

    task automatic test_single_corruption();
        logic b;
        int   pulses = 0;
        int   err_at = -1;
        int   drops  = 0;
        do_reset();
        for (int i = 1; i <= 400; i++) begin
            gen(b);
            step((i == 300) ? ~b : b, 1'b1, 1'b0);
            if (error) begin
                pulses++;
                if (err_at < 0) err_at = i;
            end
            if (i > 24 && !locked) drops++;
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL single_error_cycles got=%0d exp=1", pulses); else n_pass++;
        n_checks++;
        if (err_at !== 300) $display("FAIL single_error_position got=%0d exp=300", err_at); else n_pass++;
        n_checks++;
        if (err_count !== 16'd1) $display("FAIL single_err_count got=%0d exp=1", err_count); else n_pass++;
        n_checks++;
        if (drops !== 0) $display("FAIL single_lock_drops got=%0d exp=0", drops); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd376) $display("FAIL single_bit_count got=%0d exp=376", bit_count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic b;
        int   relock = -1;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL midreset_pre_locked got=%b exp=1", locked); else n_pass++;
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL midreset_locked got=%b exp=0", locked); else n_pass++;
        n_checks++;
        if (error !== 1'b0) $display("FAIL midreset_error got=%b exp=0", error); else n_pass++;
        n_checks++;
        if (err_count !== 16'd0) $display("FAIL midreset_err_count got=%0d exp=0", err_count); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd0) $display("FAIL midreset_bit_count got=%0d exp=0", bit_count); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 100 && relock < 0; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (locked) relock = i;
        end
        n_checks++;
        if (relock !== 24) $display("FAIL midreset_relock_bits got=%0d exp=24", relock); else n_pass++;
    endtask

    task automatic test_all_zero();
        int lock_seen = 0;
        int err_seen  = 0;
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked) lock_seen++;
            if (error) err_seen++;
        end
        n_checks++;
        if (lock_seen !== 0) $display("FAIL zero_locked_cycles got=%0d exp=0", lock_seen); else n_pass++;
        n_checks++;
        if (err_seen !== 0) $display("FAIL zero_error_cycles got=%0d exp=0", err_seen); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd0) $display("FAIL zero_bit_count got=%0d exp=0", bit_count); else n_pass++;
    endtask

    task automatic test_burst();
        logic b;
        logic locked_35 = 1'b0;
        int   relock = -1;
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            gen(b);
            step((i == 30 || i == 32 || i == 34 || i == 36) ? ~b : b, 1'b1, 1'b0);
            if (i == 35) locked_35 = locked;
        end
        n_checks++;
        if (locked_35 !== 1'b1) $display("FAIL burst_locked_after_3rd got=%b exp=1", locked_35); else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL burst_locked_after_4th got=%b exp=0", locked); else n_pass++;
        n_checks++;
        if (err_count !== 16'd4) $display("FAIL burst_err_count got=%0d exp=4", err_count); else n_pass++;
        for (int i = 1; i <= 100 && relock < 0; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (locked) relock = i;
        end
        n_checks++;
        if (relock !== 24) $display("FAIL burst_relock_bits got=%0d exp=24", relock); else n_pass++;
        n_checks++;
        if (err_count !== 16'd4) $display("FAIL burst_err_count_kept got=%0d exp=4", err_count); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd12) $display("FAIL burst_bit_count_kept got=%0d exp=12", bit_count); else n_pass++;
    endtask

    task automatic test_gapped();
        logic b;
        int   vcount = 0;
        int   lock_v = -1;
        int   idle_err = 0;
        do_reset();
        while (lock_v < 0 && vcount < 100) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            vcount++;
            if (locked) lock_v = vcount;
            step(1'($urandom_range(1, 0)), 1'b0, 1'b0);
            if (error) idle_err++;
        end
        n_checks++;
        if (lock_v !== 24) $display("FAIL gapped_lock_valid_bit got=%0d exp=24", lock_v); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            step(1'($urandom_range(1, 0)), 1'b0, 1'b0);
            if (error) idle_err++;
        end
        n_checks++;
        if (bit_count !== 16'd5) $display("FAIL gapped_bit_count got=%0d exp=5", bit_count); else n_pass++;
        n_checks++;
        if (idle_err !== 0) $display("FAIL gapped_idle_error got=%0d exp=0", idle_err); else n_pass++;
        gen(b);
        step(~b, 1'b1, 1'b1);
        n_checks++;
        if (error !== 1'b1) $display("FAIL gapped_clear_error got=%b exp=1", error); else n_pass++;
        n_checks++;
        if (err_count !== 16'd1) $display("FAIL gapped_clear_err_count got=%0d exp=1", err_count); else n_pass++;
        n_checks++;
        if (bit_count !== 16'd1) $display("FAIL gapped_clear_bit_count got=%0d exp=1", bit_count); else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (error !== 1'b0) $display("FAIL gapped_error_forced_low got=%b exp=0", error); else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL gapped_still_locked got=%b exp=1", locked); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_single_corruption();
        test_mid_reset();
        test_all_zero();
        test_burst();
        test_gapped();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
